// File: rtl/vga_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_frame_writer
// Purpose  : Streams one IMG_WIDTH x IMG_HEIGHT image into frame memory using
//            the row-major layout expected by the VGA read path.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_writer #(
  parameter int unsigned IMG_WIDTH        = 256,
  parameter int unsigned IMG_HEIGHT       = 256,
  parameter logic [31:0] BASE_OFFSET      = 32'h0,
  parameter logic [31:0] ENCRYPTED_OFFSET = 32'h10000,
  parameter int unsigned DATA_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              image_select,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   C_XW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned   C_YW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [C_XW-1:0] C_X_LAST = C_XW'(IMG_WIDTH - 1);
  localparam logic [C_YW-1:0] C_Y_LAST = C_YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [C_XW-1:0]   x_q, x_d;
  logic [C_YW-1:0]   y_q, y_d;
  logic              sel_q, sel_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [31:0]       w_pix_addr;

  // Full 32-bit sum; image_select polarity matches the VGA read decoder.
  assign w_pix_addr = (sel_q ? BASE_OFFSET : ENCRYPTED_OFFSET)
                    + (32'(y_q) * 32'(IMG_WIDTH))
                    + 32'(x_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sel_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sel_d       = sel_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pix_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = image_select;
          x_d     = '0;
          y_d     = '0;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        pix_ready = !abort;
        if (abort) begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_IDLE;
        end else if (pix_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = w_pix_addr;
          mem_wdata_d = pix_data;
          if (x_q == C_X_LAST) begin
            x_d = '0;
            // Counters are cleared on the final pixel so a non-power-of-two
            // height never leaves y parked past the last row.
            if (y_q == C_Y_LAST) begin
              y_d     = '0;
              state_d = S_DONE;
            end else begin
              y_d = y_q + C_YW'(1);
            end
          end else begin
            x_d = x_q + C_XW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_writer
// Purpose  : Self-checking bench; the k-th write of a frame is expected at
//            offset + k carrying the k-th accepted pixel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_writer;

  localparam int unsigned W    = 256;
  localparam int unsigned H    = 32;
  localparam int unsigned N    = W * H;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] ENC  = 32'h10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        image_select;
  logic        abort;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  vga_frame_writer #(
    .IMG_WIDTH        (W),
    .IMG_HEIGHT       (H),
    .BASE_OFFSET      (BASE),
    .ENCRYPTED_OFFSET (ENC),
    .DATA_W           (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .image_select (image_select),
    .abort        (abort),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; image_select = 1'b1; abort = 1'b0;
    pix_valid = 1'b1; pix_data = 8'hA5;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, pix_ready} !== 44'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h busy=%b done=%b rdy=%b want all zero",
               mem_we, mem_addr, mem_wdata, busy, done, pix_ready);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got busy=%b we=%b want 0 0", busy, mem_we);
    end
    start = 1'b0; pix_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b done=%b we=%b want 0 0 0", busy, done, mem_we);
    end
  endtask

  task automatic test_base_frame();
    int unsigned acc = 0;
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; image_select = 1'b1; pix_valid = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL base_busy: got %b want 1", busy);
    end
    while (acc < N) begin
      pix_data = 8'(acc);
      #1;
      n_cmp++;
      if (pix_ready !== 1'b1) begin
        n_bad++; $display("FAIL base_ready: got %b want 1 at pixel %0d", pix_ready, acc);
      end
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== BASE + acc || mem_wdata !== 8'(acc)) begin
        n_bad++;
        $display("FAIL base_write: got we=%b addr=%h wd=%h want 1 %h %h",
                 mem_we, mem_addr, mem_wdata, BASE + acc, 8'(acc));
      end
      n_cmp++;
      if (done !== (acc == N - 1)) begin
        n_bad++; $display("FAIL base_done: got %b want %b at pixel %0d", done, acc == N - 1, acc);
      end
      if (done === 1'b1) ndone++;
      acc++;
    end
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL base_after: got we=%b done=%b busy=%b rdy=%b want 0 0 0 0",
               mem_we, done, busy, pix_ready);
    end
    n_cmp++;
    if (ndone != 1) begin
      n_bad++; $display("FAIL base_done_count: got %0d want 1", ndone);
    end
    pix_valid = 1'b0;
  endtask

  // Encrypted frame with stray start pulses and image_select toggles.
  task automatic test_encrypted_stray();
    int unsigned acc = 0;
    logic [7:0] d;
    @(negedge clk);
    start = 1'b1; image_select = 1'b0; pix_valid = 1'b1; abort = 1'b0;
    @(negedge clk);
    while (acc < N) begin
      d = 8'($urandom);
      pix_data = d;
      start = 1'($urandom);
      image_select = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== ENC + acc || mem_wdata !== d) begin
        n_bad++;
        $display("FAIL enc_write: got we=%b addr=%h wd=%h want 1 %h %h",
                 mem_we, mem_addr, mem_wdata, ENC + acc, d);
      end
      if (acc == 517) begin
        n_cmp++;
        if (mem_addr !== 32'h10205) begin
          n_bad++; $display("FAIL enc_x5_y2: got %h want 00010205", mem_addr);
        end
      end
      n_cmp++;
      if (done !== (acc == N - 1)) begin
        n_bad++; $display("FAIL enc_done: got %b want %b at pixel %0d", done, acc == N - 1, acc);
      end
      acc++;
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL enc_after: got we=%b busy=%b done=%b want 0 0 0", mem_we, busy, done);
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int unsigned acc = 0;
    int cyc = 0;
    logic        sel;
    logic [31:0] off;
    logic [7:0]  d;
    logic        v;
    sel = 1'($urandom);
    off = sel ? BASE : ENC;
    @(negedge clk);
    start = 1'b1; image_select = sel; pix_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (acc < N && cyc < 4 * N) begin
      v = 1'($urandom);
      d = 8'($urandom);
      pix_valid = v; pix_data = d;
      image_select = 1'($urandom);
      #1;
      n_cmp++;
      if (pix_ready !== 1'b1) begin
        n_bad++; $display("FAIL bp_ready: got %b want 1", pix_ready);
      end
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (v) begin
        if (mem_we !== 1'b1 || mem_addr !== off + acc || mem_wdata !== d) begin
          n_bad++;
          $display("FAIL bp_write: got we=%b addr=%h wd=%h want 1 %h %h",
                   mem_we, mem_addr, mem_wdata, off + acc, d);
        end
      end else if (mem_we !== 1'b0) begin
        n_bad++; $display("FAIL bp_idle_we: got %b want 0 after pixel %0d", mem_we, acc);
      end
      n_cmp++;
      if (done !== (v && acc == N - 1)) begin
        n_bad++; $display("FAIL bp_done: got %b want %b", done, v && acc == N - 1);
      end
      if (v) acc++;
    end
    n_cmp++;
    if (acc != N) begin
      n_bad++; $display("FAIL bp_timeout: got %0d accepts want %0d", acc, N);
    end
    pix_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL bp_after: got we=%b busy=%b done=%b want 0 0 0", mem_we, busy, done);
    end
  endtask

  task automatic test_abort();
    int unsigned acc = 0;
    logic        sel;
    logic [31:0] off;
    sel = 1'($urandom);
    off = sel ? BASE : ENC;
    @(negedge clk);
    start = 1'b1; image_select = sel; pix_valid = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (acc < 300) begin
      pix_data = 8'(acc + 7);
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== off + acc || mem_wdata !== 8'(acc + 7)) begin
        n_bad++;
        $display("FAIL abort_pre_write: got we=%b addr=%h wd=%h want 1 %h %h",
                 mem_we, mem_addr, mem_wdata, off + acc, 8'(acc + 7));
      end
      acc++;
    end
    abort = 1'b1; pix_data = 8'hEE;
    #1;
    n_cmp++;
    if (pix_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_ready: got %b want 0", pix_ready);
    end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: got we=%b busy=%b done=%b want 0 0 0", mem_we, busy, done);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++; $display("FAIL abort_idle: got we=%b busy=%b done=%b want 0 0 0", mem_we, busy, done);
      end
    end
    sel = ~sel;
    off = sel ? BASE : ENC;
    start = 1'b1; image_select = sel;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pix_data = 8'(k + 40);
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== off + 32'(k) || mem_wdata !== 8'(k + 40)) begin
        n_bad++;
        $display("FAIL abort_restart: got we=%b addr=%h wd=%h want 1 %h %h",
                 mem_we, mem_addr, mem_wdata, off + 32'(k), 8'(k + 40));
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    int unsigned acc = 0;
    int ndone = 0;
    logic        sel;
    logic [31:0] off;
    sel = 1'($urandom);
    off = sel ? BASE : ENC;
    @(negedge clk);
    start = 1'b1; image_select = sel; pix_valid = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (acc < 1000) begin
      pix_data = 8'($urandom_range(1, 255));
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== off + acc) begin
        n_bad++;
        $display("FAIL rst_pre_write: got we=%b addr=%h want 1 %h", mem_we, mem_addr, off + acc);
      end
      acc++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, pix_ready} !== 44'h0) begin
      n_bad++;
      $display("FAIL rst_async: got we=%b addr=%h wd=%h busy=%b done=%b rdy=%b want all zero",
               mem_we, mem_addr, mem_wdata, busy, done, pix_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      n_cmp++;
      if (mem_we !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rst_after: got we=%b busy=%b want 0 0", mem_we, busy);
      end
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", ndone);
    end
    start = 1'b1; image_select = sel; pix_data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== off || mem_wdata !== 8'h3C) begin
      n_bad++;
      $display("FAIL rst_restart: got we=%b addr=%h wd=%h want 1 %h 3c", mem_we, mem_addr, mem_wdata, off);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; pix_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_base_frame();
    test_encrypted_stray();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
Loads one 256x256 8-bit image into the shared video frame memory, using the same address layout the VGA read path uses.
- Base image occupies offsets 0x00000..0x0FFFF.
- Encrypted image occupies offsets 0x10000..0x1FFFF.
- Address = offset + y*256 + x, row-major.
- Sits between the pixel source (UART/DMA loader or decrypt core) and the frame-memory write port.
- The VGA address decoder is the reader of what this block writes.

Parameters:
IMG_WIDTH, 256, pixels per row (power of two).
IMG_HEIGHT, 256, rows per image.
BASE_OFFSET, 32'h0, word offset of the base image.
ENCRYPTED_OFFSET, 32'h10000, word offset of the encrypted image.
DATA_W, 8, pixel width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a frame load (sampled only in IDLE).
image_select  input  1  1 = base image (BASE_OFFSET), 0 = encrypted image (ENCRYPTED_OFFSET); same polarity as the read path; latched at start.
abort  input  1  cancel the load in progress.
pix_valid  input  1  pixel source has data.
pix_data  input  DATA_W  pixel value.
pix_ready  output  1  block accepts a pixel this cycle.
mem_we  output  1  frame-memory write strobe.
mem_addr  output  32  frame-memory word address.
mem_wdata  output  DATA_W  frame-memory write data.
busy  output  1  high while in WRITE.
done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, x = y = 0, sel_q = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, done = 0, busy = 0, pix_ready = 0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - start = 1 -> latch sel_q <= image_select, x <= 0, y <= 0, go to WRITE.
  - pix_ready = 0; pixels are ignored.
- WRITE:
  - busy = 1.
  - pix_ready = !abort (combinational). It is the only combinational output.
  - Accept = pix_valid && pix_ready.
  - On accept:
    - Registered, latency 1: mem_we <= 1, mem_wdata <= pix_data.
    - mem_addr <= (sel_q ? BASE_OFFSET : ENCRYPTED_OFFSET) + {y, zero-extended}*IMG_WIDTH + {x, zero-extended}, all 32-bit unsigned.
    - x increments. When x == IMG_WIDTH-1, x wraps to 0 and y increments.
  - No accept -> mem_we <= 0. mem_addr and mem_wdata hold their last values.
  - Accept with x == IMG_WIDTH-1 and y == IMG_HEIGHT-1 -> go to DONE.
  - abort = 1 (takes priority over pix_valid) -> go to IDLE. No write, no done, counters cleared. Pixels already written stay in memory.
- DONE (exactly one cycle):
  - done = 1. This coincides with mem_we = 1 for the last pixel, at address offset + 0xFFFF.
  - pix_ready = 0, busy = 0.
  - Next state IDLE. abort and start are ignored here.
- start in WRITE or DONE has no effect. A changing image_select after start has no effect.
- Throughput: 1 pixel/clk with pix_valid held high. A full frame takes 65536 accepts plus 1 cycle of latency to done.
- Counters are exactly log2(IMG_WIDTH) and log2(IMG_HEIGHT) bits wide. The address sum is computed at full 32 bits, so there is no truncation.
- Reset mid-frame: immediate return to reset values. No done pulse. A later start restarts at x = y = 0.
- mem_we is never asserted outside the cycle following an accept.

Test Plan:
- Base frame: image_select = 1, start pulse, 65536 pixels with pix_data = (i & 0xFF) and pix_valid constant -> 65536 writes at consecutive addresses 0x0..0xFFFF, wdata matching. done high exactly once, in the same cycle as the write to 0xFFFF. busy low afterwards.
- Encrypted frame: image_select = 0 -> first write to 0x10000; pixel (x=5, y=2) goes to 0x10205; last write to 0x1FFFF.
- Backpressure: pix_valid random ~50% -> address sequence identical to the gap-free case, mem_we low in every cycle after a non-accept, no skipped or duplicated addresses.
- Abort: abort asserted after 300 accepts, with pix_valid high in the same cycle -> that pixel is not accepted and no write occurs. Returns to IDLE, no done. A restart writes from offset+0.
- Stray controls: start pulses and image_select toggles during WRITE -> no effect on address sequence or offset.
- Async reset at pixel 1000: outputs zero immediately, without waiting for a clock edge. After release, a new start gives a first write at offset+0.
